// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore control FSM; define MULDIV_EN to enable MUL/DIV (T6 step, HIin/LOin)
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        run,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        IncPC,
  output logic        MARin,
  output logic        memRead,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  alu_op,
  output logic        halted,
  output logic        illegal
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
  state_t state;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic is_alu, is_md, is_halt, legal, unused_ir;
  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign unused_ir = ^ir[14:0];
  assign is_alu = op >= 5'd3 && op <= 5'd10;
  assign is_halt = op == 5'd27;
`ifdef MULDIV_EN
  assign is_md = op == 5'd15 || op == 5'd16;
  assign HIin = state == T6;
  assign LOin = state == T5 && is_md;
`else
  assign is_md = 1'b0;
  assign HIin = 1'b0;
  assign LOin = 1'b0;
`endif
  assign legal = is_alu || is_md;
  // sequencing; run is only consulted when leaving IDLE, T5 or T6 so an instruction always completes
  always_ff @(posedge clock or negedge clear)
    if (!clear) state <= IDLE;
    else case (state)
      IDLE: state <= run ? T0 : IDLE;
      T0: state <= T1;
      T1: state <= mem_ready ? T2 : T1;
      T2: state <= T3;
      T3: state <= legal ? T4 : is_halt ? HALT : IDLE;
      T4: state <= T5;
      T5: state <= is_md ? T6 : run ? T0 : IDLE;
      T6: state <= run ? T0 : IDLE;
      HALT: state <= HALT;
      default: state <= IDLE;
    endcase
  assign PCout = state == T0;
  assign IncPC = state == T0;
  assign MARin = state == T0;
  assign memRead = state == T1;
  assign MDRin = state == T1;
  assign MDRout = state == T2;
  assign IRin = state == T2;
  assign Yin = state == T3 && legal;
  assign Zin = state == T4;
  assign Zlowout = state == T5;
  assign Zhighout = state == T6;
  assign alu_op = state == T4 ? op : 5'd0;
  assign Rin = state == T5 && is_alu ? 16'd1 << ra : 16'd0;
  assign halted = state == HALT;
  assign illegal = state == T3 && !legal && !is_halt;
  // operand drive: MUL/DIV read Ra then Rb, ALU ops read Rb then Rc
  always_comb begin
    Rout = 16'd0;
    if (state == T3 && legal) Rout = 16'd1 << (is_md ? ra : rb);
    else if (state == T4) Rout = 16'd1 << (is_md ? rb : rc);
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized self-checking bench for control_unit against a micro-step sequence model
module tb_control_unit;
  logic clock = 1'b0, clear = 1'b0, run = 1'b0, mem_ready = 1'b0;
  logic [31:0] ir = 32'd0;
  logic PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0] alu_op;
  logic halted, illegal;
  typedef struct packed {
    logic pc_out, inc_pc, mar_in, mem_read, mdr_in, mdr_out, ir_in, y_in, z_in, zhigh_out, zlow_out, hi_in, lo_in;
    logic [15:0] r_in, r_out;
    logic [4:0] alu_op;
    logic halted, illegal;
  } outs_t;
  outs_t o;
  outs_t exp_q[$];
  int tests = 0, fails = 0;
`ifdef MULDIV_EN
  localparam bit md_en = 1'b1;
`else
  localparam bit md_en = 1'b0;
`endif
  always #5 clock = ~clock;
  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .run(run), .mem_ready(mem_ready),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .memRead(memRead), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .halted(halted), .illegal(illegal)
  );
  assign o = {PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin,
              Rin, Rout, alu_op, halted, illegal};
  // instruction class: 0 ALU, 1 MUL/DIV, 2 HALT, 3 illegal
  function automatic int kind(logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd10) return 0;
    if (md_en && (op == 5'd15 || op == 5'd16)) return 1;
    if (op == 5'd27) return 2;
    return 3;
  endfunction
  function automatic outs_t t0_out();
    outs_t e = '0;
    e.pc_out = 1'b1; e.inc_pc = 1'b1; e.mar_in = 1'b1;
    return e;
  endfunction
  function automatic outs_t halt_out();
    outs_t e = '0;
    e.halted = 1'b1;
    return e;
  endfunction
  // expected per-cycle strobes from fetch through the last execute step, w extra memory wait cycles
  function automatic void build(logic [31:0] irv, int w);
    outs_t e;
    logic [4:0] op = irv[31:27];
    int ra = int'(irv[26:23]), rb = int'(irv[22:19]), rc = int'(irv[18:15]);
    exp_q.delete();
    exp_q.push_back(t0_out());
    for (int k = 0; k <= w; k++) begin e = '0; e.mem_read = 1'b1; e.mdr_in = 1'b1; exp_q.push_back(e); end
    e = '0; e.mdr_out = 1'b1; e.ir_in = 1'b1; exp_q.push_back(e);
    case (kind(op))
      0: begin
        e = '0; e.y_in = 1'b1; e.r_out[rb] = 1'b1; exp_q.push_back(e);
        e = '0; e.z_in = 1'b1; e.r_out[rc] = 1'b1; e.alu_op = op; exp_q.push_back(e);
        e = '0; e.zlow_out = 1'b1; e.r_in[ra] = 1'b1; exp_q.push_back(e);
      end
      1: begin
        e = '0; e.y_in = 1'b1; e.r_out[ra] = 1'b1; exp_q.push_back(e);
        e = '0; e.z_in = 1'b1; e.r_out[rb] = 1'b1; e.alu_op = op; exp_q.push_back(e);
        e = '0; e.zlow_out = 1'b1; e.lo_in = 1'b1; exp_q.push_back(e);
        e = '0; e.zhigh_out = 1'b1; e.hi_in = 1'b1; exp_q.push_back(e);
      end
      2: begin e = '0; exp_q.push_back(e); end
      default: begin e = '0; e.illegal = 1'b1; exp_q.push_back(e); end
    endcase
  endfunction
  function automatic logic [31:0] rand_ir(int cls);
    logic [4:0] op;
    if (cls == 0) op = 5'(3 + $urandom_range(0, 7));
    else if (cls == 1) op = $urandom_range(0, 1) ? 5'd15 : 5'd16;
    else begin
      op = 5'($urandom);
      while ((op >= 5'd3 && op <= 5'd10) || op == 5'd15 || op == 5'd16 || op == 5'd27) op = 5'($urandom);
    end
    return {op, 27'($urandom)};
  endfunction
  task automatic do_reset();
    @(negedge clock); clear = 1'b0; run = 1'b0; mem_ready = 1'b0;
    @(negedge clock); clear = 1'b1;
  endtask
  task automatic test_reset();
    clear = 1'b0; run = 1'b1; mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clock); tests++;
      if (o !== '0) begin fails++; $display("FAIL reset_hold got %h exp %h", o, 52'd0); end
    end
    clear = 1'b1;
    @(negedge clock); tests++;
    if (o !== t0_out()) begin fails++; $display("FAIL first_fetch got %h exp %h", o, t0_out()); end
    #2 clear = 1'b0;
    #1 tests++;
    if (o !== '0) begin fails++; $display("FAIL reset_async got %h exp %h", o, 52'd0); end
    @(negedge clock); clear = 1'b1; run = 1'b0;
    @(negedge clock); tests++;
    if (o !== '0) begin fails++; $display("FAIL idle_after_reset got %h exp %h", o, 52'd0); end
  endtask
  task automatic test_shl();
    build(32'h38918000, 0);
    @(negedge clock); ir = 32'h38918000; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock); tests++;
      if (o !== exp_q[i]) begin fails++; $display("FAIL shl step %0d got %h exp %h", i, o, exp_q[i]); end
      run = $urandom_range(0, 1);
      if (i == exp_q.size() - 1) run = 1'b1;
    end
    @(negedge clock); tests++;
    if (o !== t0_out()) begin fails++; $display("FAIL shl_then_t0 got %h exp %h", o, t0_out()); end
    do_reset();
  endtask
  task automatic test_mem_wait();
    logic [31:0] irv = rand_ir(0);
    int w = 3, cnt = 0;
    build(irv, w);
    @(negedge clock); run = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock); tests++;
      if (o !== exp_q[i]) begin fails++; $display("FAIL mem_wait step %0d got %h exp %h", i, o, exp_q[i]); end
      cnt += int'(memRead && MDRin);
      mem_ready = i >= w + 1;
      if (i == w + 2) ir = irv;
      if (i == exp_q.size() - 1) run = 1'b0;
    end
    tests++;
    if (cnt != 4) begin fails++; $display("FAIL mem_wait_cycles got %0d exp 4", cnt); end
    @(negedge clock); tests++;
    if (o !== '0) begin fails++; $display("FAIL mem_wait_idle got %h exp %h", o, 52'd0); end
  endtask
  task automatic test_muldiv();
    logic [31:0] irs[3] = '{32'h7A800000, 32'h7A280000, {5'd16, 27'($urandom)}};
    foreach (irs[n]) begin
      build(irs[n], 0);
      @(negedge clock); ir = irs[n]; run = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clock); tests++;
        if (o !== exp_q[i]) begin fails++; $display("FAIL muldiv%0d step %0d got %h exp %h", n, i, o, exp_q[i]); end
      end
      if (kind(irs[n][31:27]) == 3) begin
        @(negedge clock); tests++;
        if (o !== '0) begin fails++; $display("FAIL muldiv%0d_idle got %h exp %h", n, o, 52'd0); end
      end
      @(negedge clock); tests++;
      if (o !== t0_out()) begin fails++; $display("FAIL muldiv%0d_next_t0 got %h exp %h", n, o, t0_out()); end
      do_reset();
    end
  endtask
  task automatic test_halt();
    build(32'hD8000000, 0);
    @(negedge clock); ir = 32'hD8000000; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock); tests++;
      if (o !== exp_q[i]) begin fails++; $display("FAIL halt step %0d got %h exp %h", i, o, exp_q[i]); end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); tests++;
      if (o !== halt_out()) begin fails++; $display("FAIL halt_hold cycle %0d got %h exp %h", c, o, halt_out()); end
      mem_ready = $urandom_range(0, 1);
    end
    do_reset();
  endtask
  task automatic test_reset_mid();
    build(32'h38918000, 0);
    @(negedge clock); ir = 32'h38918000; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); tests++;
      if (o !== exp_q[i]) begin fails++; $display("FAIL rst_mid step %0d got %h exp %h", i, o, exp_q[i]); end
    end
    #2 clear = 1'b0;
    #1 tests++;
    if (o !== '0) begin fails++; $display("FAIL rst_mid_t4 got %h exp %h", o, 52'd0); end
    @(negedge clock); clear = 1'b1;
    @(negedge clock); tests++;
    if (o !== t0_out()) begin fails++; $display("FAIL rst_mid_restart got %h exp %h", o, t0_out()); end
    mem_ready = 1'b0; run = 1'b0;
    @(negedge clock); tests++;
    if (o !== exp_q[1]) begin fails++; $display("FAIL rst_wait_t1 got %h exp %h", o, exp_q[1]); end
    #2 clear = 1'b0;
    #1 tests++;
    if (o !== '0) begin fails++; $display("FAIL rst_wait_async got %h exp %h", o, 52'd0); end
    @(negedge clock); clear = 1'b1; mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clock); tests++;
      if (o !== '0) begin fails++; $display("FAIL rst_wait_abandon got %h exp %h", o, 52'd0); end
    end
  endtask
  task automatic test_run_drop();
    logic [31:0] irv = rand_ir(0);
    int w = $urandom_range(0, 2);
    build(irv, w);
    @(negedge clock); run = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock); tests++;
      if (o !== exp_q[i]) begin fails++; $display("FAIL run_drop step %0d got %h exp %h", i, o, exp_q[i]); end
      mem_ready = i >= w + 1;
      if (i == w + 2) ir = irv;
      if (i == w + 3) run = 1'b0;
    end
    repeat (3) begin
      @(negedge clock); tests++;
      if (o !== '0) begin fails++; $display("FAIL run_drop_idle got %h exp %h", o, 52'd0); end
    end
  endtask
  task automatic test_back_to_back();
    @(negedge clock); run = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] irv = rand_ir($urandom_range(0, 2));
      int w = $urandom_range(0, 3);
      logic run_after = (n < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      int k = kind(irv[31:27]);
      build(irv, w);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clock); tests++;
        if (o !== exp_q[i]) begin fails++; $display("FAIL b2b instr %0d ir %h step %0d got %h exp %h", n, irv, i, o, exp_q[i]); end
        mem_ready = (i >= 1 && i <= w + 1) ? (i >= w + 1) : 1'($urandom_range(0, 1));
        run = $urandom_range(0, 1);
        if (i == w + 2) ir = irv;
        if (i == exp_q.size() - 1) run = run_after;
      end
      if (k == 3 || !run_after) begin
        @(negedge clock); tests++;
        if (o !== '0) begin fails++; $display("FAIL b2b instr %0d idle got %h exp %h", n, o, 52'd0); end
        run = n < 39;
      end
    end
  endtask
  initial begin
    test_reset();
    test_shl();
    test_mem_wait();
    test_muldiv();
    test_halt();
    test_reset_mid();
    test_run_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
